lsu_mem: RTL and testbench
==========================

LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter PMEM_BASE, default 64'h8000_0000, byte address of storage byte 0.
REQ-002 SHALL have parameter SIZE_LOG2, default 24, storage size 2^SIZE_LOG2 bytes.
REQ-003 SHALL have parameter LATENCY, default 1, access wait cycles (legal range 1..15).
REQ-004 SHALL have ports: clock  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports: req_valid_i in 1, req_ready_o out 1, request handshake.
REQ-007 SHALL have ports: req_load_i in 1, req_store_i in 1, req_amo_i in 1, operation select.
REQ-008 SHALL have ports: req_funct3_i in 3 (width [1:0], unsigned [2]), req_funct5_i in 5 (AMO op).
REQ-009 SHALL have ports: req_addr_i in 64, req_wdata_i in 64, byte address and store/AMO operand.
REQ-010 SHALL have ports: resp_valid_o out 1, resp_ready_i in 1, response handshake.
REQ-011 SHALL have ports: resp_rdata_o out 64, resp_exc_o out 1, resp_cause_o out 64, result and exception.

Function
REQ-012 SHALL implement FSM IDLE -> WAIT -> (AMO_WR) -> RESP -> IDLE; req_ready_o=1 only in IDLE.
REQ-013 SHALL accept a request on req_valid_i & req_ready_o; all request fields are registered at acceptance.
REQ-014 SHALL, at acceptance, flag misaligned (addr mod 2^width != 0) before range fault (addr outside [PMEM_BASE, PMEM_BASE+2^SIZE_LOG2)).
REQ-015 SHALL use causes 4/5 (load misaligned/fault) and 6/7 (store or AMO misaligned/fault); an excepting request goes to RESP next cycle with no memory or reservation effect.
REQ-016 SHALL give priority amo > store > load when several select bits are set; none set completes with rdata=0, no exception.
REQ-017 SHALL stay in WAIT for exactly LATENCY cycles (counter), then perform the access.
REQ-018 SHALL store little-endian, writing only the 1/2/4/8 addressed bytes.
REQ-019 SHALL return loads zero- or sign-extended per funct3[2]; width 3 returns all 64 bits.
REQ-020 SHALL treat AMO (funct3 2=W, 3=D) as read, then write op result in AMO_WR; rdata = old value (W sign-extended).
REQ-021 SHALL support AMO ops SWAP, ADD, AND, OR, XOR, MIN, MAX, MINU, MAXU; W ops compute on bits [31:0].
REQ-022 SHALL on LR read as load and set reservation {valid, addr[63:3]}.
REQ-023 SHALL on SC write and return 0 if reservation valid and granule matches, else return 1 without writing; SC always clears reservation.
REQ-024 SHALL clear reservation on any completed store/AMO to the reserved 8-byte granule.
REQ-025 SHALL give acceptance-to-resp_valid latency LATENCY+1 (load/store/LR/SC), LATENCY+2 (other AMO), 1 (exception).
REQ-026 SHALL hold resp_* stable while resp_valid_o & !resp_ready_i; return to IDLE on cycle after handshake.
REQ-027 SHALL not accept a new request in the handshake cycle (no bypass); back-to-back throughput one per LATENCY+2 cycles.

Reset
REQ-028 SHALL on reset==0 at a clock edge force IDLE, counter 0, reservation invalid, resp_valid_o=0, resp_exc_o=0, resp_rdata_o=0, resp_cause_o=0.
REQ-029 SHALL drop any in-flight access on reset mid-operation with no memory write; storage contents are not reset.

Structure
REQ-030 SHALL take FCT5 codes, cause codes, FSM state enum and width encoding from shared package mem_pkg.
REQ-031 SHALL place AMO arithmetic in combinational sub-module amo_alu (op, width, old, operand -> new).

Verification
REQ-032 SD 0x1122334455667788 @0x80000010, LD @0x80000010 -> rdata 0x1122334455667788, latency LATENCY+1, no exc.
REQ-033 LB @0x80000017 -> 0x0000000000000011; LW after SW 0x80000000 @0x80000020 -> 0xFFFFFFFF80000000, LWU -> 0x0000000080000000.
REQ-034 LW @0x80000002 -> exc, cause 4, response in 1 cycle; SD @0x90000000 -> cause 7, memory unchanged.
REQ-035 LR.D @0x80000040, SC.D @0x80000040 -> rdata 0; repeat SC -> rdata 1, memory unchanged.
REQ-036 AMOADD.W @0x80000050 (old 0x7FFFFFFF, operand 1) -> rdata 0x7FFFFFFF, memory 0x80000000; resp_ready_i low 3 cycles -> outputs held.
REQ-037 Reset asserted during WAIT of SD -> resp_valid_o 0 next cycle, later LD shows old data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory block: FSM states, access
// widths, operation classes, AMO funct5 codes, exception causes and small
// helpers for byte lanes, alignment and load result formatting.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_AMO_WR = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WID_B = 2'd0,
    WID_H = 2'd1,
    WID_W = 2'd2,
    WID_D = 2'd3
  } width_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_AMO   = 2'd3
  } op_t;

  localparam logic [4:0] FCT5_ADD  = 5'b00000;
  localparam logic [4:0] FCT5_SWAP = 5'b00001;
  localparam logic [4:0] FCT5_LR   = 5'b00010;
  localparam logic [4:0] FCT5_SC   = 5'b00011;
  localparam logic [4:0] FCT5_XOR  = 5'b00100;
  localparam logic [4:0] FCT5_OR   = 5'b01000;
  localparam logic [4:0] FCT5_AND  = 5'b01100;
  localparam logic [4:0] FCT5_MIN  = 5'b10000;
  localparam logic [4:0] FCT5_MAX  = 5'b10100;
  localparam logic [4:0] FCT5_MINU = 5'b11000;
  localparam logic [4:0] FCT5_MAXU = 5'b11100;

  localparam logic [63:0] CAUSE_LD_MISALIGN = 64'd4;
  localparam logic [63:0] CAUSE_LD_FAULT    = 64'd5;
  localparam logic [63:0] CAUSE_ST_MISALIGN = 64'd6;
  localparam logic [63:0] CAUSE_ST_FAULT    = 64'd7;

  // Byte-lane mask of an access, before shifting to its offset in the granule.
  function automatic logic [7:0] byte_mask(input width_t w);
    logic [7:0] m;
    case (w)
      WID_B:   m = 8'h01;
      WID_H:   m = 8'h03;
      WID_W:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [63:0] addr, input width_t w);
    logic r;
    case (w)
      WID_B:   r = 1'b0;
      WID_H:   r = addr[0];
      WID_W:   r = |addr[1:0];
      default: r = |addr[2:0];
    endcase
    return r;
  endfunction

  // data holds the addressed bytes starting at bit 0.
  function automatic logic [63:0] load_format(input logic [63:0] data, input width_t w,
                                              input logic uns);
    logic [63:0] r;
    case (w)
      WID_B:   r = uns ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
      WID_H:   r = uns ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      WID_W:   r = uns ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Request/response bus between a load/store unit and lsu_mem.
//   req_*  : request handshake, operation select, funct3/funct5, address, data
//   resp_* : response handshake, read data, exception flag and cause
// master drives requests and resp_ready_i; slave (the memory) drives the rest.
interface lsu_mem_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_load_i;
  logic        req_store_i;
  logic        req_amo_i;
  logic [2:0]  req_funct3_i;
  logic [4:0]  req_funct5_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_rdata_o;
  logic        resp_exc_o;
  logic [63:0] resp_cause_o;

  modport master (
    output req_valid_i, req_load_i, req_store_i, req_amo_i, req_funct3_i,
           req_funct5_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_exc_o, resp_cause_o
  );

  modport slave (
    input  req_valid_i, req_load_i, req_store_i, req_amo_i, req_funct3_i,
           req_funct5_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_exc_o, resp_cause_o
  );
endinterface

// File: rtl/amo_alu.sv
// Combinational AMO arithmetic.
//   op      : AMO funct5 code
//   width   : WID_W computes on bits [31:0], WID_D on all 64 bits
//   old_val : value read from memory (addressed bytes at bit 0)
//   operand : store/AMO operand
//   new_val : value to write back (only the low 32 bits matter for W)
module amo_alu
  import mem_pkg::*;
(
  input  logic [4:0]  op,
  input  width_t      width,
  input  logic [63:0] old_val,
  input  logic [63:0] operand,
  output logic [63:0] new_val
);

  logic [63:0] a;
  logic [63:0] b;
  logic        lt_s;
  logic        lt_u;

  // Sign-extending both W operands keeps signed and unsigned ordering intact,
  // so one 64-bit comparator serves both widths.
  always_comb begin
    a = old_val;
    b = operand;
    if (width != WID_D) begin
      a = {{32{old_val[31]}}, old_val[31:0]};
      b = {{32{operand[31]}}, operand[31:0]};
    end
  end

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    new_val = a;
    case (op)
      FCT5_ADD:  new_val = a + b;
      FCT5_SWAP: new_val = b;
      FCT5_XOR:  new_val = a ^ b;
      FCT5_OR:   new_val = a | b;
      FCT5_AND:  new_val = a & b;
      FCT5_MIN:  new_val = lt_s ? a : b;
      FCT5_MAX:  new_val = lt_s ? b : a;
      FCT5_MINU: new_val = lt_u ? a : b;
      FCT5_MAXU: new_val = lt_u ? b : a;
      default:   new_val = a;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Single-port memory behind a load/store request/response bus with
// configurable access latency, RISC-V style loads/stores, AMOs and LR/SC.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : lsu_mem_if slave (request and response handshakes)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a request
// ST_WAIT   | counting down access latency; access happens on last cycle
// ST_AMO_WR | writing the AMO result computed from the value just read
// ST_RESP   | response valid, held until resp_ready_i
module lsu_mem
  import mem_pkg::*;
#(
  parameter logic [63:0] PMEM_BASE = 64'h8000_0000,
  parameter int          SIZE_LOG2 = 24,
  parameter int          LATENCY   = 1
) (
  input logic      clock,
  input logic      reset,
  lsu_mem_if.slave bus
);

  localparam int          IDX_W     = SIZE_LOG2 - 3;
  localparam logic [63:0] MEM_BYTES = 64'd1 << SIZE_LOG2;
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  logic [63:0] mem [2**IDX_W];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  op_t         op_q;
  width_t      width_q;
  logic        uns_q;
  logic [4:0]  funct5_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] old_q;
  logic        res_valid_q;
  logic [60:0] res_granule_q;
  logic [63:0] rdata_q;
  logic        exc_q;
  logic [63:0] cause_q;

  // ---- request decode at acceptance ----
  logic        accept;
  op_t         req_op;
  width_t      req_width;
  logic        req_misal;
  logic        req_fault;
  logic        req_exc;
  logic [63:0] req_off;
  logic [63:0] req_cause;

  assign accept    = bus.req_valid_i && (state_q == ST_IDLE);
  assign req_width = width_t'(bus.req_funct3_i[1:0]);
  assign req_misal = misaligned(bus.req_addr_i, req_width);
  assign req_off   = bus.req_addr_i - PMEM_BASE;
  assign req_fault = (bus.req_addr_i < PMEM_BASE) || (req_off >= MEM_BYTES);
  assign req_exc   = (req_op != OP_NONE) && (req_misal || req_fault);

  always_comb begin
    req_op = OP_NONE;
    if (bus.req_amo_i)        req_op = OP_AMO;
    else if (bus.req_store_i) req_op = OP_STORE;
    else if (bus.req_load_i)  req_op = OP_LOAD;
  end

  // Misalignment wins over an out-of-range address.
  always_comb begin
    if (req_op == OP_LOAD) req_cause = req_misal ? CAUSE_LD_MISALIGN : CAUSE_LD_FAULT;
    else                   req_cause = req_misal ? CAUSE_ST_MISALIGN : CAUSE_ST_FAULT;
  end

  // ---- access datapath ----
  logic [IDX_W-1:0] idx;
  logic [5:0]       sh;
  logic [63:0]      rd_word;
  logic [63:0]      rd_shift;
  logic             is_lr;
  logic             is_sc;
  logic             res_hit;
  logic [63:0]      alu_new;
  logic             mem_we;
  logic [63:0]      wr_val;
  logic [7:0]       wr_mask;
  logic [63:0]      wr_word;

  assign idx      = addr_q[SIZE_LOG2-1:3];
  assign sh       = {addr_q[2:0], 3'b000};
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> sh;
  assign is_lr    = (op_q == OP_AMO) && (funct5_q == FCT5_LR);
  assign is_sc    = (op_q == OP_AMO) && (funct5_q == FCT5_SC);
  assign res_hit  = res_valid_q && (res_granule_q == addr_q[63:3]);
  assign wr_mask  = byte_mask(width_q) << addr_q[2:0];
  assign wr_word  = wr_val << sh;

  amo_alu u_amo_alu (
    .op      (funct5_q),
    .width   (width_q),
    .old_val (old_q),
    .operand (wdata_q),
    .new_val (alu_new)
  );

  // ---- FSM ----
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    wr_val  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (req_exc || req_op == OP_NONE) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (op_q == OP_AMO && !is_lr && !is_sc) state_d = ST_AMO_WR;
          else                                    state_d = ST_RESP;
          mem_we = (op_q == OP_STORE) || (is_sc && res_hit);
        end
      end
      ST_AMO_WR: begin
        state_d = ST_RESP;
        mem_we  = 1'b1;
        wr_val  = alu_new;
      end
      ST_RESP: begin
        if (bus.resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- request/response registers, latency counter, reservation ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q         <= 4'd0;
      op_q          <= OP_NONE;
      width_q       <= WID_B;
      uns_q         <= 1'b0;
      funct5_q      <= 5'd0;
      addr_q        <= 64'd0;
      wdata_q       <= 64'd0;
      old_q         <= 64'd0;
      res_valid_q   <= 1'b0;
      res_granule_q <= 61'd0;
      rdata_q       <= 64'd0;
      exc_q         <= 1'b0;
      cause_q       <= 64'd0;
    end else if (accept) begin
      op_q     <= req_op;
      width_q  <= req_width;
      uns_q    <= bus.req_funct3_i[2];
      funct5_q <= bus.req_funct5_i;
      addr_q   <= bus.req_addr_i;
      wdata_q  <= bus.req_wdata_i;
      cnt_q    <= CNT_LOAD;
      rdata_q  <= 64'd0;
      exc_q    <= req_exc;
      cause_q  <= req_exc ? req_cause : 64'd0;
    end else if (state_q == ST_WAIT) begin
      if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end else begin
        case (op_q)
          OP_LOAD: rdata_q <= load_format(rd_shift, width_q, uns_q);
          OP_AMO: begin
            if (is_sc) begin
              rdata_q <= {63'd0, !res_hit};
            end else begin
              rdata_q <= load_format(rd_shift, width_q, 1'b0);
              old_q   <= rd_shift;
            end
          end
          default: ;
        endcase
        if (is_lr) begin
          res_valid_q   <= 1'b1;
          res_granule_q <= addr_q[63:3];
        end else if (is_sc || (op_q == OP_STORE && res_hit)) begin
          res_valid_q <= 1'b0;
        end
      end
    end else if (state_q == ST_AMO_WR && res_hit) begin
      res_valid_q <= 1'b0;
    end
  end

  // Storage is deliberately not reset; a reset edge also blocks a pending write.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
    end
  end

  assign bus.req_ready_o  = (state_q == ST_IDLE);
  assign bus.resp_valid_o = (state_q == ST_RESP);
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_exc_o   = exc_q;
  assign bus.resp_cause_o = cause_q;

endmodule

// File: tb/tb_lsu_mem.sv
module tb_lsu_mem;
  import mem_pkg::*;

  localparam int LAT = 2;
  localparam int SZ  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lsu_mem_if bus ();

  lsu_mem #(
    .PMEM_BASE (64'h8000_0000),
    .SIZE_LOG2 (SZ),
    .LATENCY   (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        ld, st, amo;
    logic [2:0]  f3;
    logic [4:0]  f5;
    logic [63:0] addr, wdata, rdata;
    logic        exc;
    logic [63:0] cause;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        exc;
    logic [63:0] cause;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic st, input logic amo, input logic [2:0] f3,
                     input logic [4:0] f5, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] rdata, input logic exc, input logic [63:0] cause,
                     input int lat);
    vec_t v;
    v.ld = ld; v.st = st; v.amo = amo; v.f3 = f3; v.f5 = f5;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.exc = exc; v.cause = cause; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic a_st(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata);
    add(1'b0, 1'b1, 1'b0, f3, 5'd0, addr, wdata, 64'd0, 1'b0, 64'd0, LAT + 1);
  endtask

  task automatic a_ld(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] exp);
    add(1'b1, 1'b0, 1'b0, f3, 5'd0, addr, 64'd0, exp, 1'b0, 64'd0, LAT + 1);
  endtask

  task automatic a_amo(input logic [2:0] f3, input logic [4:0] f5, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] exp, input int lat);
    add(1'b0, 1'b0, 1'b1, f3, f5, addr, wdata, exp, 1'b0, 64'd0, lat);
  endtask

  task automatic a_exc(input logic ld, input logic st, input logic amo, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] cause);
    add(ld, st, amo, f3, FCT5_ADD, addr, 64'd0, 64'd0, 1'b1, cause, 1);
  endtask

  task automatic idle_bus();
    bus.req_valid_i  = 1'b0;
    bus.req_load_i   = 1'b0;
    bus.req_store_i  = 1'b0;
    bus.req_amo_i    = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_funct5_i = 5'd0;
    bus.req_addr_i   = 64'd0;
    bus.req_wdata_i  = 64'd0;
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid_i  = 1'b1;
    bus.req_load_i   = v.ld;
    bus.req_store_i  = v.st;
    bus.req_amo_i    = v.amo;
    bus.req_funct3_i = v.f3;
    bus.req_funct5_i = v.f5;
    bus.req_addr_i   = v.addr;
    bus.req_wdata_i  = v.wdata;
  endtask

  // One transaction; hold > 0 keeps resp_ready_i low that many cycles after resp_valid_o.
  task automatic run_req(input vec_t v, input string name, input int hold);
    exp_t e;
    int   lat;
    int   guard;
    @(negedge clock);
    bus.resp_ready_i = (hold == 0);
    drive(v);
    sb.push_back('{rdata: v.rdata, exc: v.exc, cause: v.cause, lat: v.lat});
    guard = 0;
    while (!bus.req_ready_o && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk({name, " accept"}, 64'(bus.req_ready_o), 64'd1);
    @(posedge clock);
    #1;
    idle_bus();
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.resp_valid_o && lat < 50);
    e = sb.pop_front();
    chk({name, " latency"}, 64'(lat), 64'(e.lat));
    chk({name, " rdata"}, bus.resp_rdata_o, e.rdata);
    chk({name, " exc"}, 64'(bus.resp_exc_o), 64'(e.exc));
    chk({name, " cause"}, bus.resp_cause_o, e.cause);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        chk({name, " held valid"}, 64'(bus.resp_valid_o), 64'd1);
        chk({name, " held rdata"}, bus.resp_rdata_o, e.rdata);
        chk({name, " held ready"}, 64'(bus.req_ready_o), 64'd0);
      end
      bus.resp_ready_i = 1'b1;
      @(negedge clock);
      chk({name, " released valid"}, 64'(bus.resp_valid_o), 64'd0);
      chk({name, " released ready"}, 64'(bus.req_ready_o), 64'd1);
    end
  endtask

  task automatic one(input logic ld, input logic st, input logic amo, input logic [2:0] f3,
                     input logic [4:0] f5, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] rdata, input int lat, input string name, input int hold);
    vec_t v;
    v.ld = ld; v.st = st; v.amo = amo; v.f3 = f3; v.f5 = f5;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.exc = 1'b0; v.cause = 64'd0; v.lat = lat;
    run_req(v, name, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[$];
    int diff;
    int guard;

    idle_bus();
    bus.resp_ready_i = 1'b1;

    // ---- stimulus table ----
    a_st(3'd3, 64'h8000_0010, 64'h1122_3344_5566_7788);
    a_ld(3'd3, 64'h8000_0010, 64'h1122_3344_5566_7788);
    a_ld(3'd0, 64'h8000_0017, 64'h0000_0000_0000_0011);
    a_ld(3'd0, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FF88);
    a_ld(3'd4, 64'h8000_0010, 64'h0000_0000_0000_0088);
    a_ld(3'd1, 64'h8000_0012, 64'h0000_0000_0000_5566);
    a_ld(3'd5, 64'h8000_0016, 64'h0000_0000_0000_1122);
    a_st(3'd3, 64'h8000_0020, 64'hAAAA_AAAA_AAAA_AAAA);
    a_st(3'd2, 64'h8000_0020, 64'hDEAD_BEEF_8000_0000);
    a_ld(3'd2, 64'h8000_0020, 64'hFFFF_FFFF_8000_0000);
    a_ld(3'd6, 64'h8000_0020, 64'h0000_0000_8000_0000);
    a_ld(3'd3, 64'h8000_0020, 64'hAAAA_AAAA_8000_0000);
    a_st(3'd0, 64'h8000_0013, 64'h0000_0000_0000_005A);
    a_ld(3'd3, 64'h8000_0010, 64'h1122_3344_5A66_7788);
    a_exc(1'b1, 1'b0, 1'b0, 3'd2, 64'h8000_0002, 64'd4);
    a_exc(1'b0, 1'b1, 1'b0, 3'd3, 64'h9000_0000, 64'd7);
    a_exc(1'b1, 1'b0, 1'b0, 3'd3, 64'h7FFF_FFF8, 64'd5);
    a_exc(1'b0, 1'b1, 1'b0, 3'd1, 64'h8000_0001, 64'd6);
    a_exc(1'b1, 1'b0, 1'b0, 3'd2, 64'h9000_0002, 64'd4);
    a_exc(1'b0, 1'b0, 1'b1, 3'd2, 64'h8000_0052, 64'd6);
    a_exc(1'b1, 1'b0, 1'b0, 3'd3, 64'h8001_0000, 64'd5);
    a_st(3'd3, 64'h8000_FFF8, 64'h0102_0304_0506_0708);
    a_ld(3'd3, 64'h8000_FFF8, 64'h0102_0304_0506_0708);
    add(1'b0, 1'b0, 1'b0, 3'd3, 5'd0, 64'h8000_0010, 64'd0, 64'd0, 1'b0, 64'd0, 1);
    add(1'b1, 1'b1, 1'b0, 3'd3, 5'd0, 64'h8000_0030, 64'hCAFE_F00D_1234_5678,
        64'd0, 1'b0, 64'd0, LAT + 1);
    a_ld(3'd3, 64'h8000_0030, 64'hCAFE_F00D_1234_5678);
    a_st(3'd3, 64'h8000_0040, 64'h0000_0000_0000_0123);
    a_amo(3'd3, FCT5_LR, 64'h8000_0040, 64'd0, 64'h123, LAT + 1);
    a_amo(3'd3, FCT5_SC, 64'h8000_0040, 64'h456, 64'd0, LAT + 1);
    a_ld(3'd3, 64'h8000_0040, 64'h456);
    a_amo(3'd3, FCT5_SC, 64'h8000_0040, 64'h789, 64'd1, LAT + 1);
    a_ld(3'd3, 64'h8000_0040, 64'h456);
    a_amo(3'd3, FCT5_LR, 64'h8000_0040, 64'd0, 64'h456, LAT + 1);
    a_st(3'd2, 64'h8000_0044, 64'h999);
    a_amo(3'd3, FCT5_SC, 64'h8000_0040, 64'h777, 64'd1, LAT + 1);
    a_ld(3'd3, 64'h8000_0040, 64'h0000_0999_0000_0456);
    a_st(3'd2, 64'h8000_0050, 64'h7FFF_FFFF);
    a_amo(3'd2, FCT5_ADD, 64'h8000_0050, 64'd1, 64'h0000_0000_7FFF_FFFF, LAT + 2);
    a_ld(3'd2, 64'h8000_0050, 64'hFFFF_FFFF_8000_0000);
    a_amo(3'd2, FCT5_SWAP, 64'h8000_0050, 64'd1, 64'hFFFF_FFFF_8000_0000, LAT + 2);
    a_ld(3'd6, 64'h8000_0050, 64'd1);
    a_st(3'd3, 64'h8000_0058, 64'd5);
    a_amo(3'd3, FCT5_MIN, 64'h8000_0058, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, LAT + 2);
    a_amo(3'd3, FCT5_MAXU, 64'h8000_0058, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, LAT + 2);
    a_amo(3'd2, FCT5_XOR, 64'h8000_005C, 64'h0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, LAT + 2);
    a_ld(3'd3, 64'h8000_0058, 64'hF0F0_F0F0_FFFF_FFFD);
    a_amo(3'd2, FCT5_MAX, 64'h8000_0058, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, LAT + 2);
    a_ld(3'd3, 64'h8000_0058, 64'hF0F0_F0F0_0000_0001);
    a_amo(3'd3, FCT5_AND, 64'h8000_0058, 64'hFF00_FF00_FF00_FF00,
          64'hF0F0_F0F0_0000_0001, LAT + 2);
    a_amo(3'd3, FCT5_OR, 64'h8000_0058, 64'h0000_0000_0000_00F0,
          64'hF000_F000_0000_0000, LAT + 2);
    a_amo(3'd2, FCT5_MINU, 64'h8000_0058, 64'h10, 64'hF0, LAT + 2);
    a_ld(3'd3, 64'h8000_0058, 64'hF000_F000_0000_0010);

    // ---- reset state ----
    repeat (3) @(negedge clock);
    chk("reset resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("reset req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("reset rdata", bus.resp_rdata_o, 64'd0);
    chk("reset exc", 64'(bus.resp_exc_o), 64'd0);
    chk("reset cause", bus.resp_cause_o, 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_req(vecs[i], $sformatf("v%0d", i), 0);

    // ---- AMO response held under backpressure ----
    one(1'b0, 1'b1, 1'b0, 3'd2, 5'd0, 64'h8000_0060, 64'h7FFF_FFFF, 64'd0, LAT + 1, "bp_sw", 0);
    one(1'b0, 1'b0, 1'b1, 3'd2, FCT5_ADD, 64'h8000_0060, 64'd1, 64'h7FFF_FFFF, LAT + 2,
        "bp_amoadd", 3);
    one(1'b1, 1'b0, 1'b0, 3'd2, 5'd0, 64'h8000_0060, 64'd0, 64'hFFFF_FFFF_8000_0000, LAT + 1,
        "bp_lw", 0);

    // ---- back-to-back throughput, valid held high ----
    @(negedge clock);
    bus.resp_ready_i = 1'b1;
    bus.req_valid_i  = 1'b1;
    bus.req_load_i   = 1'b1;
    bus.req_funct3_i = 3'd3;
    bus.req_addr_i   = 64'h8000_0010;
    for (int c = 0; c < 40 && acc.size() < 2; c++) begin
      if (bus.req_ready_o) acc.push_back(c);
      @(negedge clock);
    end
    idle_bus();
    diff = (acc.size() == 2) ? acc[1] - acc[0] : -1;
    chk("throughput interval", 64'(diff), 64'(LAT + 2));
    guard = 0;
    while ((bus.resp_valid_o || !bus.req_ready_o) && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    chk("throughput drained", 64'(bus.req_ready_o), 64'd1);

    // ---- reset on the access cycle of a store ----
    one(1'b0, 1'b0, 1'b1, 3'd3, FCT5_LR, 64'h8000_0040, 64'd0, 64'h0000_0999_0000_0456,
        LAT + 1, "rst_lr", 0);
    @(negedge clock);
    bus.req_valid_i  = 1'b1;
    bus.req_store_i  = 1'b1;
    bus.req_funct3_i = 3'd3;
    bus.req_addr_i   = 64'h8000_0010;
    bus.req_wdata_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    guard = 0;
    while (!bus.req_ready_o && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("rst_sd accept", 64'(bus.req_ready_o), 64'd1);
    @(posedge clock);
    #1;
    idle_bus();
    repeat (LAT) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_sd resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_sd req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_sd rdata", bus.resp_rdata_o, 64'd0);
    chk("rst_sd exc", 64'(bus.resp_exc_o), 64'd0);
    reset = 1'b1;
    one(1'b1, 1'b0, 1'b0, 3'd3, 5'd0, 64'h8000_0010, 64'd0, 64'h1122_3344_5A66_7788,
        LAT + 1, "rst_ld_old", 0);
    one(1'b0, 1'b0, 1'b1, 3'd3, FCT5_SC, 64'h8000_0040, 64'h1234, 64'd1, LAT + 1,
        "rst_sc_noresv", 0);
    one(1'b1, 1'b0, 1'b0, 3'd3, 5'd0, 64'h8000_0040, 64'd0, 64'h0000_0999_0000_0456,
        LAT + 1, "rst_ld_resv", 0);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
